// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and refill-side handshake bundle for the instruction cache
//
// Purpose: groups the fetch request/response, flush and memory refill signals.
// Ports (signals):
//   req_valid/req_ready/req_addr         fetch request from the fetch stage
//   resp_valid/resp_data                 one-cycle instruction response
//   flush_i                              invalidate all lines (fence.i)
//   mem_req_valid/mem_req_ready/mem_req_addr   refill word request
//   mem_resp_valid/mem_resp_data         refill word return
// Modports: slave = the cache, master = fetch stage plus memory.
interface icache_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  flush_i;
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic                  mem_resp_valid;
   logic [DATA_WIDTH-1:0] mem_resp_data;

   modport slave (
      input  req_valid, req_addr, flush_i, mem_req_ready, mem_resp_valid, mem_resp_data,
      output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
   );

   modport master (
      output req_valid, req_addr, flush_i, mem_req_ready, mem_resp_valid, mem_resp_data,
      input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
   );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped blocking instruction cache with in-order line refill
//
// Purpose: serves one fetch at a time; hits answer in the LOOKUP cycle, misses
// refill the whole line word by word (offset 0 first) and answer from DONE.
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        icache_if.slave (fetch request/response, flush, memory refill)
//   hit_cnt    32-bit LOOKUP hit count   (only with ICACHE_PERF_EN)
//   miss_cnt   32-bit LOOKUP miss count  (only with ICACHE_PERF_EN)
// Configuration macro: ICACHE_PERF_EN adds the hit/miss counters.
module icache #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   icache_if.slave     bus
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);
   localparam int OFF_W    = $clog2(LINE_WORDS);
   localparam int IDX_W    = $clog2(NUM_LINES);
   localparam int LINE_LSB = OFF_W + 2;
   localparam int TAG_W    = ADDR_WIDTH - IDX_W - LINE_LSB;

   typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  lookup_hit;
   logic                  flush_pend;
   logic [OFF_W-1:0]      cnt;
   logic [NUM_LINES-1:0]  valid;
   logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
   logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];

   logic                  resp_valid_q;
   logic [DATA_WIDTH-1:0] resp_data_q;
   logic                  mem_req_valid_q;
   logic [ADDR_WIDTH-1:0] mem_req_addr_q;

   logic [OFF_W-1:0] req_off, q_off;
   logic [IDX_W-1:0] req_idx, q_idx;
   logic [TAG_W-1:0] req_tag, q_tag;
   logic             req_hit, last_word, to_idle;
   logic             unused_byte_bits;

   assign req_off = bus.req_addr[2 +: OFF_W];
   assign req_idx = bus.req_addr[LINE_LSB +: IDX_W];
   assign req_tag = bus.req_addr[ADDR_WIDTH-1 -: TAG_W];
   assign q_off   = addr_q[2 +: OFF_W];
   assign q_idx   = addr_q[LINE_LSB +: IDX_W];
   assign q_tag   = addr_q[ADDR_WIDTH-1 -: TAG_W];
   assign unused_byte_bits = ^{bus.req_addr[1:0], addr_q[1:0]};

   assign req_hit   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign last_word = (cnt == OFF_W'(LINE_WORDS - 1));
   assign to_idle   = ((state == LOOKUP) && lookup_hit) || (state == DONE);

   // req_ready has to fall in the very cycle flush_i is raised, so it is a
   // decode of the state and the flush input rather than a register.
   assign bus.req_ready     = (state == IDLE) && !bus.flush_i;
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_data     = resp_data_q;
   assign bus.mem_req_valid = mem_req_valid_q;
   assign bus.mem_req_addr  = mem_req_addr_q;

   // Tag/data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if ((state == REFILL_WAIT) && bus.mem_resp_valid)
         data_mem[{q_idx, cnt}] <= bus.mem_resp_data;
      if (state == DONE)
         tag_mem[q_idx] <= q_tag;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         addr_q          <= '0;
         lookup_hit      <= 1'b0;
         flush_pend      <= 1'b0;
         cnt             <= '0;
         valid           <= '0;
         resp_valid_q    <= 1'b0;
         resp_data_q     <= '0;
         mem_req_valid_q <= 1'b0;
         mem_req_addr_q  <= '0;
`ifdef ICACHE_PERF_EN
         hit_cnt         <= '0;
         miss_cnt        <= '0;
`endif
      end else begin
         resp_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.flush_i) begin
                  valid <= '0;
               end else if (bus.req_valid) begin
                  // The tag compare is done against the incoming address so the
                  // hit response is already registered during LOOKUP.
                  addr_q       <= bus.req_addr;
                  lookup_hit   <= req_hit;
                  resp_valid_q <= req_hit;
                  resp_data_q  <= data_mem[{req_idx, req_off}];
                  state        <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (lookup_hit) begin
                  state <= IDLE;
`ifdef ICACHE_PERF_EN
                  hit_cnt <= hit_cnt + 32'd1;
`endif
               end else begin
                  valid[q_idx]    <= 1'b0;
                  cnt             <= '0;
                  mem_req_valid_q <= 1'b1;
                  mem_req_addr_q  <= {addr_q[ADDR_WIDTH-1:LINE_LSB], {OFF_W{1'b0}}, 2'b00};
                  state           <= REFILL_REQ;
`ifdef ICACHE_PERF_EN
                  miss_cnt <= miss_cnt + 32'd1;
`endif
               end
            end
            REFILL_REQ: begin
               if (bus.mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state           <= REFILL_WAIT;
               end
            end
            REFILL_WAIT: begin
               if (bus.mem_resp_valid) begin
                  if (last_word) begin
                     // The requested word may be the one arriving right now.
                     resp_valid_q <= 1'b1;
                     resp_data_q  <= (q_off == cnt) ? bus.mem_resp_data
                                                    : data_mem[{q_idx, q_off}];
                     state        <= DONE;
                  end else begin
                     cnt             <= cnt + OFF_W'(1);
                     mem_req_valid_q <= 1'b1;
                     mem_req_addr_q  <= {addr_q[ADDR_WIDTH-1:LINE_LSB], cnt + OFF_W'(1), 2'b00};
                     state           <= REFILL_REQ;
                  end
               end
            end
            DONE: begin
               valid[q_idx] <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // A flush seen while busy is deferred to the return to IDLE and then
         // wipes every line, the one just refilled included.
         if (state != IDLE) begin
            if (bus.flush_i)
               flush_pend <= 1'b1;
            if (to_idle && (flush_pend || bus.flush_i)) begin
               valid      <= '0;
               flush_pend <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache against a line-level cache model
module tb_icache;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   icache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt, miss_cnt;
   icache dut (.clk(clk), .rst_n(rst_n), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
   icache dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: which line holds which tag, plus hit/miss tallies
   bit          m_valid [16];
   logic [23:0] m_tag   [16];
   int          m_hits  = 0;
   int          m_misses = 0;

   // memory side
   int          ready_mode = 0;   // 0 always ready, 1 random, 2 stalled
   bit          stray = 1'b0;
   bit          hs_prev = 1'b0;
   logic [31:0] hs_addr;
   logic [31:0] req_log [$];

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      case (a)
         32'h8000_0000: return 32'h0000_0413;
         32'h8000_0004: return 32'h0010_0093;
         32'h8000_0008: return 32'h0020_0113;
         32'h8000_000C: return 32'h0030_0193;
         default:       return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   // memory: accepts a word request and returns its data one cycle later
   initial begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      forever begin
         @(negedge clk);
         bus.mem_resp_valid = hs_prev || stray;
         bus.mem_resp_data  = hs_prev ? mem_val(hs_addr) : 32'hDEAD_BEEF;
         bus.mem_req_ready  = (ready_mode == 0) ? 1'b1 :
                              (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 1) == 1);
         hs_prev = bus.mem_req_valid && bus.mem_req_ready;
         hs_addr = bus.mem_req_addr;
         if (hs_prev) req_log.push_back(hs_addr);
      end
   end

   task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
      @(negedge clk);
      req_log.delete();
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      #1 check("accept_ready", bus.req_ready, 1'b1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      d = bus.resp_data;
      if (!bus.resp_valid) lat = -1;
   endtask

   task automatic verify_fetch(input logic [31:0] a, input string tag);
      logic [31:0] d, exp_addr, obs_addr;
      int          lat;
      logic [3:0]  idx;
      bit          exp_hit;
      idx     = a[7:4];
      exp_hit = m_valid[idx] && (m_tag[idx] == a[31:8]);
      fetch(a, d, lat);
      check({tag, "_data"}, d, mem_val({a[31:2], 2'b00}));
      if (exp_hit) begin
         m_hits++;
         check({tag, "_hit_latency"}, lat, 1);
         check({tag, "_hit_memreqs"}, req_log.size(), 0);
      end else begin
         m_misses++;
         check({tag, "_miss_memreqs"}, req_log.size(), 4);
         for (int i = 0; i < 4; i++) begin
            exp_addr = {a[31:4], 4'h0} + 32'(4 * i);
            obs_addr = (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
            check({tag, "_miss_addr"}, obs_addr, exp_addr);
         end
         if (ready_mode == 0) check({tag, "_miss_latency"}, lat, 10);
         else                 check({tag, "_miss_latency_min"}, 32'(lat >= 10), 1);
         m_valid[idx] = 1'b1;
         m_tag[idx]   = a[31:8];
      end
   endtask

   task automatic idle_flush(input logic [31:0] a);
      @(negedge clk);
      bus.flush_i   = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      #1 check("flush_blocks_ready", bus.req_ready, 1'b0);
      @(negedge clk);
      bus.flush_i   = 1'b0;
      bus.req_valid = 1'b0;
      #1 check("flush_req_not_taken", bus.req_ready, 1'b1);
      check("flush_no_resp", bus.resp_valid, 1'b0);
      model_clear();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: observed=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.flush_i   = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_resp_data", bus.resp_data, 32'h0);
      check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
      check("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
      check("rst_req_ready", bus.req_ready, 1'b1);
`ifdef ICACHE_PERF_EN
      check("rst_hit_cnt", hit_cnt, 32'h0);
      check("rst_miss_cnt", miss_cnt, 32'h0);
`endif
      rst_n = 1'b1;

      // cold miss then hit in the filled line
      verify_fetch(32'h8000_0000, "cold");
      verify_fetch(32'h8000_0008, "hit_after_fill");
`ifdef ICACHE_PERF_EN
      check("perf_hit_cnt", hit_cnt, 32'd1);
      check("perf_miss_cnt", miss_cnt, 32'd1);
`endif

      // conflict on index 0
      verify_fetch(32'h8000_0100, "conflict_a");
      verify_fetch(32'h8000_0000, "conflict_b");

      // flush in IDLE wins over a request
      idle_flush(32'h8000_0000);
      verify_fetch(32'h8000_0004, "after_idle_flush");

      // flush during a refill: response still returns, line ends up invalid
      fork
         verify_fetch(32'h8000_0010, "flush_inflight");
         begin
            repeat (4) @(negedge clk);
            bus.flush_i = 1'b1;
            @(negedge clk);
            bus.flush_i = 1'b0;
         end
      join
      model_clear();
      verify_fetch(32'h8000_0010, "after_pending_flush");
      verify_fetch(32'h8000_0014, "after_pending_flush_hit");

      // random traffic over a few conflicting lines with random memory readiness
      ready_mode = 1;
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = 32'h8000_0000 | 32'($urandom_range(0, 3) << 8)
                           | 32'($urandom_range(0, 3) << 4)
                           | 32'($urandom_range(0, 3) << 2);
         if ($urandom_range(0, 9) == 0) idle_flush(a);
         verify_fetch(a, "rand");
      end
`ifdef ICACHE_PERF_EN
      check("perf_rand_hits", hit_cnt, 32'(m_hits));
      check("perf_rand_misses", miss_cnt, 32'(m_misses));
`endif

      // backpressure then reset in the middle of a refill
      ready_mode = 2;
      @(negedge clk);
      req_log.delete();
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h8000_0040;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("stall_mem_req_valid", bus.mem_req_valid, 1'b1);
         check("stall_mem_req_addr", bus.mem_req_addr, 32'h8000_0040);
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("reset_drops_mem_req", bus.mem_req_valid, 1'b0);
      check("reset_no_resp", bus.resp_valid, 1'b0);
      check("stall_no_handshake", req_log.size(), 0);
      rst_n = 1'b1;
      model_clear();
      m_hits   = 0;
      m_misses = 0;
      ready_mode = 0;
      @(posedge clk);
      #1 stray = 1'b1;
      @(posedge clk);
      #1 stray = 1'b0;
      @(negedge clk);
      check("stray_ignored_resp", bus.resp_valid, 1'b0);
      check("stray_ignored_ready", bus.req_ready, 1'b1);
      verify_fetch(32'h8000_0000, "after_reset");
`ifdef ICACHE_PERF_EN
      check("perf_after_reset_hits", hit_cnt, 32'(m_hits));
      check("perf_after_reset_misses", miss_cnt, 32'(m_misses));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, fetch address width; SHALL be 32.
REQ-002 Parameter DATA_WIDTH, default 32, instruction/word width; SHALL be 32.
REQ-003 Parameter LINE_WORDS, default 4, words per line; SHALL be a power of two, at least 2.
REQ-004 Parameter NUM_LINES, default 16, direct-mapped lines; SHALL be a power of two, at least 2.
REQ-005 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  1  fetch request from the fetch stage.
REQ-008 req_ready  out  1  cache accepts a request this cycle.
REQ-009 req_addr  in  ADDR_WIDTH  fetch PC.
REQ-010 resp_valid  out  1  resp_data valid; a one-cycle pulse; the consumer SHALL always accept it.
REQ-011 resp_data  out  DATA_WIDTH  instruction word.
REQ-012 flush_i  in  1  invalidate all lines (fence.i).
REQ-013 mem_req_valid  out  1  refill word request.
REQ-014 mem_req_ready  in  1  memory accepts the request.
REQ-015 mem_req_addr  out  ADDR_WIDTH  word-aligned refill address.
REQ-016 mem_resp_valid  in  1  refill data valid.
REQ-017 mem_resp_data  in  DATA_WIDTH  refill word.

Function
REQ-018 Address split SHALL be: bits [1:0] ignored; word offset = next log2(LINE_WORDS) bits; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
REQ-019 The FSM SHALL have the states IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT and DONE.
REQ-020 req_ready SHALL be 1 only in IDLE with no flush applied that cycle; a request is accepted on req_valid&&req_ready, latching the address, and the FSM SHALL move to LOOKUP.
REQ-021 LOOKUP, hit (valid && tag match): resp_valid=1 with the stored word in that same cycle, i.e. 1 cycle after acceptance; next state IDLE.
REQ-022 LOOKUP, miss: resp_valid=0, word counter=0, line valid bit cleared; next state REFILL_REQ.
REQ-023 REFILL_REQ SHALL drive mem_req_valid=1 with mem_req_addr = line base + 4*counter, holding both stable until mem_req_ready; it then moves to REFILL_WAIT. At most one request is outstanding.
REQ-024 REFILL_WAIT: on mem_resp_valid, store the word at the counter slot; if counter==LINE_WORDS-1 go to DONE, else increment the counter and go to REFILL_REQ. Words are fetched in order, offset 0 first.
REQ-025 DONE: write the tag, set the valid bit, resp_valid=1 with the requested word (taken from the line buffer), next state IDLE; the miss latency is therefore refill time + 2 cycles after acceptance.
REQ-026 mem_resp_valid outside REFILL_WAIT SHALL be ignored.
REQ-027 flush_i in IDLE SHALL clear all valid bits in that cycle; it SHALL take priority over a simultaneous req_valid (req_ready=0).
REQ-028 flush_i outside IDLE SHALL set a pending flag, and the in-flight request SHALL complete normally; on entering IDLE all valid bits SHALL be cleared, including the line just refilled.
REQ-029 resp_valid, mem_req_valid and req_ready SHALL be 0 in every state not listed above as driving them.

Reset
REQ-030 With rst_n=0 at a clock edge: state=IDLE, all valid bits=0, counter=0, pending flush=0; resp_valid=0, resp_data=0, mem_req_valid=0, mem_req_addr=0; req_ready=1 in the first cycle after reset.
REQ-031 Reset during REFILL_* SHALL abandon the refill, with no line made valid; late memory responses SHALL be ignored per REQ-026.
REQ-032 Data and tag arrays need not be reset.

Configuration
REQ-033 Macro ICACHE_PERF_EN defined: add outputs hit_cnt and miss_cnt, each 32 bits and out, counting LOOKUP hits and misses, reset to 0, wrapping at 2^32, unaffected by flush; undefined: these ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-034 Cold miss: request 0x80000000; memory returns 0x00000413, 0x00100093, 0x00200113 and 0x00300193 with 1-cycle latency; required: 4 mem requests at 0x80000000, 0x80000004, 0x80000008 and 0x8000000C, and resp_data=0x00000413.
REQ-035 Hit after fill: request 0x80000008 -> resp_valid 1 cycle after acceptance, resp_data=0x00200113, and no mem_req_valid.
REQ-036 Conflict: fill 0x80000000, then request 0x80000100 (same index, different tag) -> miss and refill; then request 0x80000000 -> miss again.
REQ-037 Flush: flush_i asserted during a refill of 0x80000010 -> the response still returns; a following request to 0x80000010 misses.
REQ-038 Backpressure and reset: hold mem_req_ready=0 for 5 cycles, then assert rst_n=0 -> mem_req_valid=0 after the edge; a stray mem_resp_valid is ignored; the next request 0x80000000 misses.
REQ-039 With ICACHE_PERF_EN: the REQ-034 and REQ-035 sequence -> hit_cnt=1, miss_cnt=1.
